sipo_reg: RTL and testbench
===========================

SIPO_REG -- requirements
Module: sipo_reg

Interface
REQ-001 SHALL have parameter: WIDTH, 8, number of data bits per frame (2..32).
REQ-002 SHALL have port: clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port: rst  input  1  synchronous active-high reset, sampled on clk rising edge.
REQ-004 SHALL have port: start  input  1  begin new frame (pulse).
REQ-005 SHALL have port: bit_in  input  1  serial data bit from upstream d_latch output.
REQ-006 SHALL have port: bit_en  input  1  sample strobe; bit_in is valid when high.
REQ-007 SHALL have port: out_data  output  WIDTH  assembled parallel word.
REQ-008 SHALL have port: out_valid  output  1  out_data holds a complete frame.
REQ-009 SHALL have port: out_ready  input  1  consumer accepts word when high with out_valid.
REQ-010 SHALL have port: busy  output  1  high in SHIFT state.
REQ-011 SHALL have port: overrun  output  1  sticky; bit strobe arrived while word unaccepted.
REQ-012 SHALL have port: par_err  output  1  parity mismatch for current word (see Configuration).

Function
REQ-013 SHALL implement FSM states IDLE, SHIFT, HOLD; all outputs registered.
REQ-014 IDLE: bit_en ignored; start=1 -> SHIFT, bit counter cleared, shift register cleared.
REQ-015 SHIFT: each cycle with bit_en=1 SHALL shift bit_in into LSB (first bit ends up MSB) and increment counter.
REQ-016 SHIFT: on the bit_en cycle completing the frame, SHALL move to HOLD; out_valid=1 and out_data updated on that same clock edge (latency 1 cycle from last strobe).
REQ-017 SHIFT: start=1 SHALL abort frame: counter and shift register cleared, remain in SHIFT; if bit_en also high that cycle, the bit is taken as first bit of new frame.
REQ-018 HOLD: out_data and out_valid SHALL stay stable until out_valid & out_ready.
REQ-019 HOLD accept without start -> IDLE, out_valid=0 next cycle; accept with start=1 same cycle -> SHIFT directly.
REQ-020 HOLD: start without accept SHALL be ignored.
REQ-021 HOLD: bit_en=1 with no accept SHALL drop the bit and set overrun; overrun clears only on reset.
REQ-022 Counter width SHALL be $clog2(WIDTH+1)+1 bits; counter SHALL never wrap past frame length.

Reset
REQ-023 rst=1 SHALL force IDLE, out_data=0, out_valid=0, busy=0, overrun=0, par_err=0, counter=0, regardless of state, including mid-frame.
REQ-024 rst SHALL take priority over start, bit_en and out_ready in the same cycle.

Configuration
REQ-025 Macro SIPO_PARITY_EN defined: frame SHALL be WIDTH data bits plus one trailing even-parity bit; parity bit not stored in out_data; par_err=1 with out_valid when XOR of data bits != parity bit, cleared on accept.
REQ-026 Macro SIPO_PARITY_EN undefined: frame SHALL be WIDTH bits; par_err tied 0; no parity logic present.

Structure
REQ-027 FSM state encoding (IDLE=2'd0, SHIFT=2'd1, HOLD=2'd2) SHALL live in shared package sipo_pkg, with default WIDTH constant.
REQ-028 Bit counter SHALL be a sub-module bit_counter (clear, increment, terminal-count output); no other sub-modules.

Verification
REQ-029 Reset then start, 8 strobes bits 1,0,1,1,0,0,1,0 -> out_data=8'hB2, out_valid=1 one edge after 8th strobe, busy=0.
REQ-030 out_ready held low 5 cycles in HOLD -> out_data stays 8'hB2; ready=1 -> out_valid=0 next cycle, state IDLE.
REQ-031 After 3 strobes assert start, then 8 strobes of 8'h5A -> out_data=8'h5A (partial frame discarded).
REQ-032 bit_en pulse in HOLD without ready -> overrun=1, out_data unchanged; stays 1 until rst.
REQ-033 rst asserted after 4 strobes -> all outputs 0 next edge; subsequent bit_en without start produces no out_valid.
REQ-034 With SIPO_PARITY_EN: 8'hB2 plus parity 0 -> par_err=0; plus parity 1 -> par_err=1 with out_valid.

Source files
------------

// File: rtl/sipo_pkg.sv
// Shared types and defaults for the serial-in/parallel-out frame assembler.
package sipo_pkg;

  // Frame FSM state encoding
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2
  } sipo_state_t;

  // Default number of data bits per frame
  localparam int SIPO_WIDTH_DEF = 8;

endpackage

// File: rtl/bit_counter.sv
// Frame bit counter: clear (optionally counting the same-cycle strobe),
// saturating increment, terminal-count flag on the last position of a frame.
module bit_counter #(
  parameter int CW   = 5,
  parameter int LAST = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic tc
);

  logic [CW-1:0] cnt;

  assign tc = (cnt == CW'(LAST - 1));

  // Clear wins; a strobe taken together with clear counts as bit one.
  // Increment stops at the terminal position so the count never wraps.
  always_ff @(posedge clk) begin
    if (rst)              cnt <= '0;
    else if (clr)         cnt <= inc ? CW'(1) : '0;
    else if (inc && !tc)  cnt <= cnt + CW'(1);
  end

endmodule

// File: rtl/sipo_reg.sv
// Serial-in/parallel-out frame register with IDLE/SHIFT/HOLD handshake.
// Optional feature: define SIPO_PARITY_EN to append a trailing even-parity
// bit to each frame and report mismatches on par_err.
module sipo_reg
  import sipo_pkg::*;
#(
  parameter int WIDTH = SIPO_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             bit_in,
  input  logic             bit_en,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             overrun,
  output logic             par_err
);

`ifdef SIPO_PARITY_EN
  localparam int PAR_BITS = 1;
`else
  localparam int PAR_BITS = 0;
`endif
  localparam int FRAME_LEN = WIDTH + PAR_BITS;
  localparam int CW        = $clog2(WIDTH + 1) + 1;

  sipo_state_t      state, state_n;
  logic [WIDTH-1:0] sh;
  logic [WIDTH-1:0] ld_word;
  logic             tc;
  logic             cnt_clr, cnt_inc, sh_clr, shift_en;
  logic             load, accept, drop;

  bit_counter #(.CW(CW), .LAST(FRAME_LEN)) u_cnt (
    .clk (clk),
    .rst (rst),
    .clr (cnt_clr),
    .inc (cnt_inc),
    .tc  (tc)
  );

  // With parity the last strobe carries the parity bit, so the word is
  // already complete in sh; otherwise the last strobe is the word's LSB.
`ifdef SIPO_PARITY_EN
  assign ld_word = sh;
`else
  assign ld_word = {sh[WIDTH-2:0], bit_in};
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Next-state and datapath control decode
  always_comb begin
    state_n  = state;
    cnt_clr  = 1'b0;
    cnt_inc  = 1'b0;
    sh_clr   = 1'b0;
    shift_en = 1'b0;
    load     = 1'b0;
    accept   = 1'b0;
    drop     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_n = SHIFT;
          cnt_clr = 1'b1;
          sh_clr  = 1'b1;
        end
      end
      SHIFT: begin
        if (start) begin
          // Abort: restart frame, a coincident strobe is the new first bit
          cnt_clr = 1'b1;
          sh_clr  = 1'b1;
          if (bit_en) begin
            cnt_inc  = 1'b1;
            shift_en = 1'b1;
          end
        end else if (bit_en) begin
          if (tc) begin
            load    = 1'b1;
            cnt_clr = 1'b1;
            state_n = HOLD;
          end else begin
            shift_en = 1'b1;
            cnt_inc  = 1'b1;
          end
        end
      end
      HOLD: begin
        if (out_ready) begin
          accept = 1'b1;
          if (start) begin
            state_n = SHIFT;
            cnt_clr = 1'b1;
            sh_clr  = 1'b1;
          end else begin
            state_n = IDLE;
          end
        end else if (bit_en) begin
          drop = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Shift register, output word, handshake flags and sticky overrun
  always_ff @(posedge clk) begin
    if (rst) begin
      sh        <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      busy <= (state_n == SHIFT);
      if (sh_clr)        sh <= shift_en ? {{(WIDTH-1){1'b0}}, bit_in} : '0;
      else if (shift_en) sh <= {sh[WIDTH-2:0], bit_in};
      if (load) begin
        out_data  <= ld_word;
        out_valid <= 1'b1;
      end else if (accept) begin
        out_valid <= 1'b0;
      end
      if (drop) overrun <= 1'b1;
    end
  end

`ifdef SIPO_PARITY_EN
  // Even parity: data bits XOR parity bit must be zero; flag lives with the word
  always_ff @(posedge clk) begin
    if (rst)         par_err <= 1'b0;
    else if (load)   par_err <= (^sh) ^ bit_in;
    else if (accept) par_err <= 1'b0;
  end
`else
  assign par_err = 1'b0;
`endif

endmodule

// File: tb/tb_sipo_reg.sv
// Directed bench for sipo_reg (WIDTH=8). Parity cases run when
// SIPO_PARITY_EN is defined.
module tb_sipo_reg;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       bit_in = 1'b0;
  logic       bit_en = 1'b0;
  logic       out_ready = 1'b0;
  logic [7:0] out_data;
  logic       out_valid, busy, overrun, par_err;

  int n_chk  = 0;
  int n_pass = 0;

  sipo_reg #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .bit_in    (bit_in),
    .bit_en    (bit_en),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .overrun   (overrun),
    .par_err   (par_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 unit after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Serial word MSB first, followed by the parity bit when enabled
  task automatic send_frame(input logic [7:0] w, input logic par);
    for (int i = 7; i >= 0; i--) begin
      bit_in = w[i];
      bit_en = 1'b1;
      tick();
    end
`ifdef SIPO_PARITY_EN
    bit_in = par;
    bit_en = 1'b1;
    tick();
`else
    if (par) bit_in = 1'b0;
`endif
    bit_en = 1'b0;
    bit_in = 1'b0;
  endtask

  initial begin
    // Reset state
    rst = 1'b1;
    tick();
    tick();
    chk("rst_data", out_data, 8'h00);
    chk("rst_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ovr", overrun, 0);
    chk("rst_perr", par_err, 0);
    rst = 1'b0;

    // Basic frame B2
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_busy", busy, 1);
    send_frame(8'hB2, 1'b0);
    chk("b2_data", out_data, 8'hB2);
    chk("b2_valid", out_valid, 1);
    chk("b2_busy", busy, 0);
    chk("b2_perr", par_err, 0);

    // Hold with consumer stalled
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("hold_data", out_data, 8'hB2);
      chk("hold_valid", out_valid, 1);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("acc_valid", out_valid, 0);
    chk("acc_busy", busy, 0);

    // Abort after 3 bits, then full 5A frame
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bit_in = 1'b1;
      bit_en = 1'b1;
      tick();
    end
    bit_en = 1'b0;
    start  = 1'b1;
    tick();
    start = 1'b0;
    chk("abort_busy", busy, 1);
    chk("abort_valid", out_valid, 0);
    send_frame(8'h5A, 1'b0);
    chk("5a_data", out_data, 8'h5A);
    chk("5a_valid", out_valid, 1);

    // Start in HOLD without accept is ignored
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("hstart_busy", busy, 0);
    chk("hstart_valid", out_valid, 1);

    // Strobe in HOLD without accept: overrun, word kept
    bit_in = 1'b1;
    bit_en = 1'b1;
    tick();
    bit_en = 1'b0;
    chk("ovr_set", overrun, 1);
    chk("ovr_data", out_data, 8'h5A);

    // Accept with start goes straight to SHIFT; overrun stays sticky
    out_ready = 1'b1;
    start     = 1'b1;
    tick();
    out_ready = 1'b0;
    start     = 1'b0;
    chk("accst_busy", busy, 1);
    chk("accst_valid", out_valid, 0);
    chk("ovr_sticky", overrun, 1);

    // Mid-frame reset with competing start/strobe
    for (int i = 0; i < 4; i++) begin
      bit_in = 1'b1;
      bit_en = 1'b1;
      tick();
    end
    rst   = 1'b1;
    start = 1'b1;
    tick();
    rst   = 1'b0;
    start = 1'b0;
    bit_en = 1'b0;
    chk("mrst_data", out_data, 8'h00);
    chk("mrst_valid", out_valid, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_ovr", overrun, 0);
    chk("mrst_perr", par_err, 0);

    // Strobes without start are ignored in IDLE
    for (int i = 0; i < 10; i++) begin
      bit_in = 1'b1;
      bit_en = 1'b1;
      tick();
    end
    bit_en = 1'b0;
    chk("idle_valid", out_valid, 0);
    chk("idle_busy", busy, 0);
    chk("idle_data", out_data, 8'h00);

`ifdef SIPO_PARITY_EN
    // Good parity then bad parity
    start = 1'b1;
    tick();
    start = 1'b0;
    send_frame(8'hB2, 1'b0);
    chk("par0_valid", out_valid, 1);
    chk("par0_err", par_err, 0);
    out_ready = 1'b1;
    start     = 1'b1;
    tick();
    out_ready = 1'b0;
    start     = 1'b0;
    send_frame(8'hB2, 1'b1);
    chk("par1_valid", out_valid, 1);
    chk("par1_data", out_data, 8'hB2);
    chk("par1_err", par_err, 1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("par_clr", par_err, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
